// File: rtl/msk_aes_word_loader.sv
// Input stage of the masked AES core: collects eight masked 32-bit words (4 key words,
// then 4 plaintext words) and hands both 128-bit sharings to the core in one transfer.
module msk_aes_word_loader #(
    parameter int d = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic [32*d-1:0]   sh_data_in,
    output logic              valid_out,
    input  logic              core_in_ready,
    output logic [128*d-1:0]  sh_key,
    output logic [128*d-1:0]  sh_plaintext
);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [128*d-1:0]   key_q, key_d;
    logic [128*d-1:0]   pt_q, pt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= 3'd0;
            key_q   <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        pt_d    = pt_q;
        case (state_q)
            LOAD: begin
                if (data_in_valid) begin
                    // cnt[2] selects key vs plaintext, cnt[1:0] the word slot
                    for (int w = 0; w < 4; w++) begin
                        if (cnt_q[1:0] == 2'(w)) begin
                            if (!cnt_q[2]) key_d[w*32*d +: 32*d] = sh_data_in;
                            else           pt_d[w*32*d +: 32*d]  = sh_data_in;
                        end
                    end
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = FULL;
                end
            end
            FULL: begin
                if (core_in_ready) begin
                    key_d   = '0;
                    pt_d    = '0;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign valid_out     = (state_q == FULL);
    assign data_in_ready = (state_q == LOAD);

    // Per-share AND gating; shares are never combined with each other.
    assign sh_key       = key_q & {(128*d){valid_out}};
    assign sh_plaintext = pt_q  & {(128*d){valid_out}};

endmodule

// File: tb/tb_msk_aes_word_loader.sv
// Scoreboard bench for msk_aes_word_loader at d = 2.
module tb_msk_aes_word_loader;

    localparam int D = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             data_in_valid;
    logic             data_in_ready;
    logic [32*D-1:0]  sh_data_in;
    logic             valid_out;
    logic             core_in_ready;
    logic [128*D-1:0] sh_key;
    logic [128*D-1:0] sh_plaintext;

    msk_aes_word_loader #(.d(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .sh_data_in    (sh_data_in),
        .valid_out     (valid_out),
        .core_in_ready (core_in_ready),
        .sh_key        (sh_key),
        .sh_plaintext  (sh_plaintext)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] key_sh;
        logic [255:0] pt_sh;
        logic [127:0] key;
        logic [127:0] pt;
    } blk_t;

    blk_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   acc_cnt = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] unmask(input logic [255:0] s);
        logic [127:0] v;
        for (int j = 0; j < 128; j++) v[j] = s[2*j] ^ s[2*j+1];
        return v;
    endfunction

    // Transfer monitor: pops the scoreboard on every handshake, checks gating otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_in_valid && data_in_ready) acc_cnt++;
            if (valid_out && core_in_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_xfer", 1, 0);
                end else begin
                    blk_t e;
                    e = sb.pop_front();
                    chk("xfer_key_shares", sh_key, e.key_sh);
                    chk("xfer_pt_shares", sh_plaintext, e.pt_sh);
                    chk("xfer_key_value", {128'd0, unmask(sh_key)}, {128'd0, e.key});
                    chk("xfer_pt_value", {128'd0, unmask(sh_plaintext)}, {128'd0, e.pt});
                end
            end
            if (!valid_out) begin
                chk("zero_gate_key", sh_key, '0);
                chk("zero_gate_pt", sh_plaintext, '0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_word(input logic [31:0] v);
        logic [31:0] r;
        logic [63:0] w;
        r = $urandom;
        for (int j = 0; j < 32; j++) begin
            w[2*j]   = r[j];
            w[2*j+1] = v[j] ^ r[j];
        end
        return w;
    endfunction

    task automatic send_words(input logic [127:0] k, input logic [127:0] p,
                              input int nwords, input int maxgap);
        blk_t e;
        logic [63:0] w;
        logic [31:0] v;
        e.key = k;
        e.pt  = p;
        for (int i = 0; i < nwords; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                data_in_valid = 1'b0;
                sh_data_in    = {$urandom, $urandom};
                tick();
            end
            v = (i < 4) ? k[32*i +: 32] : p[32*(i-4) +: 32];
            w = mk_word(v);
            if (i < 4) e.key_sh[64*i +: 64]    = w;
            else       e.pt_sh[64*(i-4) +: 64] = w;
            if (i == 7) begin
                chk("lat_pre_valid", valid_out, 0);
                chk("load_ready", data_in_ready, 1);
                sb.push_back(e);
            end
            data_in_valid = 1'b1;
            sh_data_in    = w;
            tick();
            data_in_valid = 1'b0;
        end
        if (nwords == 8) begin
            chk("lat_post_valid", valid_out, 1);
            chk("full_ready", data_in_ready, 0);
        end
    endtask

    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] held_k, held_p;
        logic [127:0] k2, p2;
        int acc0;
        rst           = 1'b1;
        data_in_valid = 1'b0;
        sh_data_in    = '0;
        core_in_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", data_in_ready, 1);
        chk("rst_valid", valid_out, 0);
        chk("rst_key", sh_key, '0);
        chk("rst_pt", sh_plaintext, '0);
        rst = 1'b0;

        // 1: nominal back-to-back, core always ready
        core_in_ready = 1'b1;
        send_words(KEY0, PT0, 8, 0);
        tick();
        chk("s1_valid_one_cycle", valid_out, 0);
        chk("s1_ready_back", data_in_ready, 1);
        chk("s1_zero_key_reg", dut.key_q, '0);
        chk("s1_zero_pt_reg", dut.pt_q, '0);

        // 2: back-pressure for 5 cycles with junk on the input
        core_in_ready = 1'b0;
        send_words(KEY0, PT0, 8, 0);
        held_k = sh_key;
        held_p = sh_plaintext;
        chk("s2_held_vs_sb", held_k, sb[0].key_sh);
        for (int c = 0; c < 5; c++) begin
            data_in_valid = 1'b1;
            sh_data_in    = {$urandom, $urandom};
            tick();
            chk("s2_valid_hold", valid_out, 1);
            chk("s2_ready_low", data_in_ready, 0);
            chk("s2_key_hold", sh_key, held_k);
            chk("s2_pt_hold", sh_plaintext, held_p);
        end
        data_in_valid = 1'b0;
        core_in_ready = 1'b1;
        tick();
        chk("s2_xfer_6th_edge", valid_out, 0);
        chk("s2_ready_after", data_in_ready, 1);
        chk("s2_cnt_clean", {253'd0, dut.cnt_q}, 0);

        // 3: gapped input, exactly 8 acceptances
        acc0 = acc_cnt;
        k2 = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom, $urandom, $urandom};
        send_words(k2, p2, 8, 3);
        chk("s3_accepts", acc_cnt - acc0, 8);
        tick();

        // 4: reset after 3 words, then full load
        send_words(k2, p2, 3, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s4_cnt_zero", {253'd0, dut.cnt_q}, 0);
        chk("s4_key_zero", dut.key_q, '0);
        chk("s4_pt_zero", dut.pt_q, '0);
        send_words(KEY0, ~PT0, 8, 1);
        tick();

        // 5: zeroization persists until the next block completes
        for (int c = 0; c < 4; c++) begin
            chk("s5_key_reg", dut.key_q, '0);
            chk("s5_pt_reg", dut.pt_q, '0);
            tick();
        end
        send_words(PT0, KEY0, 2, 0);
        chk("s5_partial_gated", sh_key, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 6: reset coincides with transfer while FULL
        core_in_ready = 1'b0;
        send_words(KEY0, PT0, 8, 0);
        rst = 1'b1;
        core_in_ready = 1'b1;
        tick();
        rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        chk("s6_load", data_in_ready, 1);
        chk("s6_key_zero", dut.key_q, '0);
        chk("s6_pt_zero", dut.pt_q, '0);
        for (int c = 0; c < 3; c++) begin
            chk("s6_no_pulse", valid_out, 0);
            tick();
        end

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/msk_aes_word_loader.md
# msk_aes_word_loader

Upstream input stage for the masked 32-bit AES core. It accepts the masked key and plaintext as a stream of eight 32-bit masked words over a valid/ready handshake. It assembles them into full 128-bit bit-compact sharings and presents both to the core's `valid_in`/`in_ready` handshake in a single transfer. Buffered sensitive data is zeroized after every transfer and on reset, and the outputs are forced to the zero sharing whenever they are not valid.

## Interface

**Parameters**
- `d`, default 2: masking order (number of shares per bit).

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: clock. Single clock domain.
- `rst`, in, 1: reset, synchronous, active-high.
- `data_in_valid`, in, 1: upstream word valid.
- `data_in_ready`, out, 1: loader accepts a word this cycle.
- `sh_data_in`, in, 32*d: one masked 32-bit word, bit-compact; shares of bit j are at [j*d +: d].
- `valid_out`, out, 1: drives the core `valid_in`.
- `core_in_ready`, in, 1: driven by the core `in_ready`.
- `sh_key`, out, 128*d: masked key to the core `sh_key`.
- `sh_plaintext`, out, 128*d: masked plaintext to the core `sh_plaintext`.

## Operation

**Word order.** A block is exactly 8 words.
- Words 0..3 are key words 0..3.
- Words 4..7 are plaintext words 0..3.
- Word w of a 128-bit value occupies bits [32w+31:32w]. Its sharing goes to slice [32*w*d +: 32*d].

**State.**
- `cnt`: 3-bit word counter.
- `key_reg` and `pt_reg`: 128*d bits each.
- FSM with two states, LOAD and FULL.

**LOAD state.**
- `data_in_ready` = 1.
- A word is accepted when `data_in_valid` && `data_in_ready`. On acceptance:
  - write the word into `key_reg` (cnt 0..3) or `pt_reg` (cnt 4..7) at word index cnt mod 4;
  - increment `cnt`.
- Accepting the word at cnt = 7 moves the FSM to FULL, and `cnt` wraps to 0.
- Cycles with `data_in_valid` = 0 hold all state.

**FULL state.**
- `data_in_ready` = 0 and `valid_out` = 1.
- Transfer occurs when `core_in_ready` = 1. On that edge:
  - both registers are cleared to all-zero;
  - the FSM returns to LOAD.
- While `core_in_ready` = 0, the registers and `valid_out` hold indefinitely.

**Outputs.**
- `valid_out` = (state == FULL).
- `sh_key` = `key_reg` when `valid_out`, else the all-zero sharing. `sh_plaintext` follows the same rule with `pt_reg`.
- The gating is a per-share AND with `valid_out`. No recombination of shares is allowed anywhere in the block.

**Share handling.**
- Shares are stored and forwarded bit-exactly. No share XOR or refresh is applied.

**Boundary conditions.**
- Reset in any state: next edge gives LOAD, `cnt` = 0, both registers zero. A partially loaded block is discarded.
- `rst` takes priority over a simultaneous word acceptance or transfer.
- No word can be accepted in the transfer cycle, because `data_in_ready` = 0 in FULL. There is therefore no simultaneous load/transfer case.
- `data_in_valid` held high continuously: 8 words are accepted on 8 consecutive edges.

## Timing

- **Reset values:** `data_in_ready` = 1, `valid_out` = 0, `sh_key` = 0, `sh_plaintext` = 0.
- `data_in_ready` and `valid_out` are decoded from registered state only, with no combinational path from any input.
- **Latency:** the 8th word is accepted on edge N; `valid_out` = 1 in the cycle after edge N.
- **Transfer:** happens on the first edge with `core_in_ready` = 1 while FULL. `data_in_ready` = 1 in the following cycle.
- **Throughput:** one block per 9 cycles minimum, with a continuous stream and the core always ready.

## Test plan

All scenarios use d = 2. Word values are built as share0 = random r, share1 = value ^ r.

1. **Nominal load.** Key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, streamed back-to-back with `core_in_ready` = 1.
   - `valid_out` rises one cycle after the 8th acceptance and stays high exactly 1 cycle.
   - The unmasked `sh_key` and `sh_plaintext` equal the given values.
   - Each output share equals the corresponding input share bit-for-bit.
2. **Back-pressure.** Same data, `core_in_ready` = 0 for 5 cycles after FULL.
   - `valid_out` and both outputs are held stable for 5 cycles.
   - `data_in_ready` = 0 throughout, and an asserted `data_in_valid` is ignored.
   - Transfer occurs on the 6th edge.
3. **Gapped input.** `data_in_valid` toggles 1,0,0,1,... with random gaps.
   - Exactly 8 acceptances fill the block.
   - Word placement is unchanged versus scenario 1.
4. **Reset mid-load.** Assert `rst` after 3 words.
   - Next cycle: `cnt` = 0 and the registers are zero.
   - A subsequent full 8-word load yields the correct block, with no residue from the aborted words.
5. **Zeroization.** After a transfer:
   - the internal registers are all-zero;
   - `sh_key` and `sh_plaintext` read the all-zero sharing;
   - this holds until the next block completes.
6. **Reset priority.** Assert `rst` in the FULL state on the same edge as `core_in_ready` = 1.
   - Result is LOAD with registers zero.
   - No second `valid_out` pulse occurs.
